// File: rtl/apb_master_fsm.sv
// APB master bridge: single-beat valid/ready commands to APB SETUP/ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_master_fsm #(
   parameter int AWIDTH  = 4,
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [DWIDTH-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [AWIDTH-1:0] PADDR,
   output logic [DWIDTH-1:0] PWDATA,
   input  logic [DWIDTH-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [AWIDTH-1:0] paddr_q, paddr_d;
   logic [DWIDTH-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_write ? cmd_wdata : '0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = PSLVERR;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               state_d     = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            // This wait edge would bring the count to TIMEOUT: give up.
            else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_d;
   end
`endif

   assign cmd_ready = (state_q == IDLE);
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with a small register-file slave model.
// Timeout scenario runs only when APB_TIMEOUT_EN is defined (TIMEOUT = 16).
module tb_apb_master_fsm;

   logic       PCLK;
   logic       PRESETn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [3:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   int total;
   int bad;

   logic [7:0] mem [16];

   wire [14:0] bus = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
   wire [9:0]  rsp = {rsp_valid, rsp_err, rsp_rdata};

   apb_master_fsm #(
      .AWIDTH(4),
      .DWIDTH(8),
      .TIMEOUT(16)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   initial begin
      PCLK = 1'b1;
      forever #5 PCLK = ~PCLK;
   end

   // Slave register file: writes land on the completing ACCESS edge.
   always @(posedge PCLK)
      if (PSEL && PENABLE && PREADY && PWRITE)
         mem[PADDR] <= PWDATA;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         total++;
         if (bus !== 15'h0) begin
            bad++;
            $display("FAIL reset_hold: bus=%h want 0", bus);
         end
      end
      #10 PRESETn = 1'b1;
      #1;
      total++;
      if ({bus, rsp} !== 25'h0) begin
         bad++;
         $display("FAIL reset_outs: got %h want 0", {bus, rsp});
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b want 1", cmd_ready);
      end
      @(negedge PCLK);
      total++;
      if (PSEL !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_psel: got %b want 0", PSEL);
      end
   endtask

   task automatic test_write();
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 4'h2;
      cmd_wdata = 8'hA5;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL wr_ready: got %b want 1", cmd_ready);
      end
      @(negedge PCLK);
      cmd_valid = 1'b0;
      total++;
      if ({bus, cmd_ready} !== {1'b1, 1'b0, 1'b1, 4'h2, 8'hA5, 1'b0}) begin
         bad++;
         $display("FAIL wr_setup: got %h want %h", {bus, cmd_ready},
                  {1'b1, 1'b0, 1'b1, 4'h2, 8'hA5, 1'b0});
      end
      @(negedge PCLK);
      total++;
      if (bus !== {1'b1, 1'b1, 1'b1, 4'h2, 8'hA5}) begin
         bad++;
         $display("FAIL wr_access: got %h want %h", bus,
                  {1'b1, 1'b1, 1'b1, 4'h2, 8'hA5});
      end
      @(negedge PCLK);
      total++;
      if ({bus, rsp, cmd_ready} !==
          {1'b0, 1'b0, 1'b1, 4'h2, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}) begin
         bad++;
         $display("FAIL wr_rsp: got %h want %h", {bus, rsp, cmd_ready},
                  {1'b0, 1'b0, 1'b1, 4'h2, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1});
      end
      @(negedge PCLK);
      total++;
      if (rsp !== 10'h0) begin
         bad++;
         $display("FAIL wr_pulse_end: got %h want 0", rsp);
      end
      total++;
      if (mem[2] !== 8'hA5) begin
         bad++;
         $display("FAIL wr_slave_reg2: got %h want a5", mem[2]);
      end
   endtask

   task automatic test_read_wait();
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'h1;
      cmd_wdata = 8'hFF;
      PREADY    = 1'b0;
      PSLVERR   = 1'b1;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      total++;
      if (bus !== {1'b1, 1'b0, 1'b0, 4'h1, 8'h00}) begin
         bad++;
         $display("FAIL rd_setup: got %h want %h", bus,
                  {1'b1, 1'b0, 1'b0, 4'h1, 8'h00});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         total++;
         if ({bus, rsp_valid} !== {1'b1, 1'b1, 1'b0, 4'h1, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL rd_access_%0d: got %h want %h", i, {bus, rsp_valid},
                     {1'b1, 1'b1, 1'b0, 4'h1, 8'h00, 1'b0});
         end
         if (i == 3) begin
            PREADY  = 1'b1;
            PRDATA  = 8'h3C;
            PSLVERR = 1'b0;
         end
      end
      @(negedge PCLK);
      total++;
      if ({bus, rsp} !== {1'b0, 1'b0, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 8'h3C}) begin
         bad++;
         $display("FAIL rd_rsp: got %h want %h", {bus, rsp},
                  {1'b0, 1'b0, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 8'h3C});
      end
   endtask

   task automatic test_back_to_back();
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'hF;
      cmd_wdata = 8'h00;
      PREADY    = 1'b1;
      @(negedge PCLK);
      cmd_write = 1'b1;
      cmd_addr  = 4'h3;
      cmd_wdata = 8'h5A;
      total++;
      if ({bus, cmd_ready} !== {1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL b2b_setup1: got %h want %h", {bus, cmd_ready},
                  {1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 1'b0});
      end
      @(negedge PCLK);
      PSLVERR = 1'b1;
      PRDATA  = 8'h77;
      total++;
      if (bus !== {1'b1, 1'b1, 1'b0, 4'hF, 8'h00}) begin
         bad++;
         $display("FAIL b2b_access1: got %h want %h", bus,
                  {1'b1, 1'b1, 1'b0, 4'hF, 8'h00});
      end
      @(negedge PCLK);
      PSLVERR = 1'b0;
      total++;
      if ({rsp, cmd_ready} !== {1'b1, 1'b1, 8'h77, 1'b1}) begin
         bad++;
         $display("FAIL b2b_rsp1_err: got %h want %h", {rsp, cmd_ready},
                  {1'b1, 1'b1, 8'h77, 1'b1});
      end
      @(negedge PCLK);
      cmd_valid = 1'b0;
      total++;
      if ({bus, rsp} !== {1'b1, 1'b0, 1'b1, 4'h3, 8'h5A, 1'b0, 1'b1, 8'h77}) begin
         bad++;
         $display("FAIL b2b_setup2: got %h want %h", {bus, rsp},
                  {1'b1, 1'b0, 1'b1, 4'h3, 8'h5A, 1'b0, 1'b1, 8'h77});
      end
      @(negedge PCLK);
      total++;
      if (bus !== {1'b1, 1'b1, 1'b1, 4'h3, 8'h5A}) begin
         bad++;
         $display("FAIL b2b_access2: got %h want %h", bus,
                  {1'b1, 1'b1, 1'b1, 4'h3, 8'h5A});
      end
      @(negedge PCLK);
      total++;
      if (rsp !== {1'b1, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL b2b_rsp2: got %h want %h", rsp, {1'b1, 1'b0, 8'h00});
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, mem[3]} !== {1'b0, 8'h5A}) begin
         bad++;
         $display("FAIL b2b_slave_reg3: got %h want %h", {PSEL, mem[3]},
                  {1'b0, 8'h5A});
      end
   endtask

   task automatic test_reset_mid();
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'h4;
      PREADY    = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         bad++;
         $display("FAIL rst_mid_pre: got %b want 11", {PSEL, PENABLE});
      end
      #2 PRESETn = 1'b0;
      #1;
      total++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
         bad++;
         $display("FAIL rst_mid_async: got %b want 000", {PSEL, PENABLE, rsp_valid});
      end
      @(negedge PCLK);
      #2 PRESETn = 1'b1;
      PREADY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge PCLK);
         total++;
         if ({bus, rsp, cmd_ready} !== {25'h0, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid_after_%0d: got %h want %h", i,
                     {bus, rsp, cmd_ready}, {25'h0, 1'b1});
         end
      end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 4'h5;
      PREADY    = 1'b0;
      PRDATA    = 8'hAA;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge PCLK);
         total++;
         if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
            bad++;
            $display("FAIL to_wait_%0d: got %b want 110", i,
                     {PSEL, PENABLE, rsp_valid});
         end
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, rsp} !== {2'b00, 1'b1, 1'b1, 8'h00}) begin
         bad++;
         $display("FAIL to_rsp: got %h want %h", {PSEL, PENABLE, rsp},
                  {2'b00, 1'b1, 1'b1, 8'h00});
      end
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
         bad++;
         $display("FAIL to_idle: got %b want 0001",
                  {PSEL, PENABLE, rsp_valid, cmd_ready});
      end
      PREADY = 1'b1;
   endtask
`endif

   initial begin
      total     = 0;
      bad       = 0;
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 4'h0;
      cmd_wdata = 8'h00;
      PRDATA    = 8'h00;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_reset_mid();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
